// File: rtl/sample_strobe_gen_if.sv
// Control and strobe bundle between the bench/replay engine and sample_strobe_gen.
// Per-channel fields are packed with channel i at [i*DIV_WIDTH +: DIV_WIDTH].
interface sample_strobe_gen_if #(
  parameter int CHANNELS  = 2,
  parameter int DIV_WIDTH = 16,
  parameter int CNT_WIDTH = 32
);
  logic                          enable;
  logic                          clear;
  logic [CHANNELS*DIV_WIDTH-1:0] div;
  logic [CHANNELS*DIV_WIDTH-1:0] phase;
  logic [CNT_WIDTH-1:0]          total_points;
  logic [CHANNELS-1:0]           strobe;
  logic [CNT_WIDTH-1:0]          point_cnt;
  logic                          busy;
  logic                          done;

  modport master (
    output enable, clear, div, phase, total_points,
    input  strobe, point_cnt, busy, done
  );

  modport slave (
    input  enable, clear, div, phase, total_points,
    output strobe, point_cnt, busy, done
  );
endinterface

// File: rtl/sample_strobe_gen.sv
// Multi-channel clock-enable strobe generator with per-channel divide and phase,
// counting channel-0 strobes and stopping itself after a programmed point count.
module sample_strobe_gen #(
  parameter int CHANNELS  = 2,
  parameter int DIV_WIDTH = 16,
  parameter int CNT_WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  sample_strobe_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e                              state_q, state_d;
  logic [CHANNELS-1:0][DIV_WIDTH-1:0]  div_q, div_d;
  logic [CHANNELS-1:0][DIV_WIDTH-1:0]  phase_q, phase_d;
  logic [CHANNELS-1:0][DIV_WIDTH-1:0]  cd_q, cd_d;
  logic [CNT_WIDTH-1:0]                total_q, total_d;
  logic [CNT_WIDTH-1:0]                cnt_q, cnt_d;
  logic [CHANNELS-1:0]                 strobe_q, strobe_d;
  logic                                busy_q, busy_d;
  logic                                done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      div_q    <= '0;
      phase_q  <= '0;
      cd_q     <= '0;
      total_q  <= '0;
      cnt_q    <= '0;
      strobe_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      phase_q  <= phase_d;
      cd_q     <= cd_d;
      total_q  <= total_d;
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // busy/done are registered from the current state, so they lag it by one edge.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    phase_d  = phase_q;
    cd_d     = cd_q;
    total_d  = total_q;
    cnt_d    = cnt_q;
    strobe_d = '0;
    busy_d   = (state_q == ARM) || (state_q == RUN);
    done_d   = (state_q == DONE);

    case (state_q)
      IDLE: begin
        if (bus.enable) begin
          state_d = ARM;
          div_d   = bus.div;
          phase_d = bus.phase;
          total_d = bus.total_points;
        end
      end
      ARM: begin
        if (total_q == '0) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
          cd_d    = phase_q;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (bus.enable) begin
          for (int i = 0; i < CHANNELS; i++) begin
            strobe_d[i] = (cd_q[i] == '0);
            cd_d[i]     = strobe_d[i] ? div_q[i] : cd_q[i] - DIV_WIDTH'(1);
          end
          if (strobe_d[0]) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
            if (cnt_d == total_q) begin
              state_d = DONE;
            end
          end
        end
      end
      DONE: begin
        if (!bus.enable) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over everything, including the terminal-count transition.
    if (bus.clear) begin
      state_d  = IDLE;
      strobe_d = '0;
      cnt_d    = '0;
    end
  end

  assign bus.strobe    = strobe_q;
  assign bus.point_cnt = cnt_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
